edge_detect_multi: RTL and testbench

Parametrised, multi-channel successor to the single-bit edge detector. Each channel synchronises an asynchronous input and detects rising and/or falling edges, selected per channel at run time. Each channel drives a one-cycle pulse and a sticky status flag. A shared interrupt line and a saturating event counter summarise activity for the status/IRQ block.

---
 rtl/edge_detect_multi.sv | 187 ++++++++++++++++++
 tb/tb_edge_detect_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi
// Multi-channel edge detector. Every channel synchronises an asynchronous
// input, detects rising and/or falling edges (selected per channel at run
// time), drives a one-cycle pulse and a sticky flag. A masked interrupt line
// and a saturating event counter summarise activity for the status block.
//
// Build option: define EDGE_DETECT_MULTI_DEBOUNCE_EN to insert a per-channel
// debounce filter between the synchroniser and the detector. Without it the
// DEB_CYCLES parameter has no effect on the datapath.

module edge_detect_multi #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int DEB_CYCLES  = 4
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] mode_rise,
   input  logic [WIDTH-1:0] mode_fall,
   input  logic [WIDTH-1:0] irq_en,
   input  logic [WIDTH-1:0] clr,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] pulse,
   output logic [WIDTH-1:0] sticky,
   output logic             irq,
   output logic [CNT_W-1:0] edge_cnt
);

`ifdef EDGE_DETECT_MULTI_DEBOUNCE_EN
   localparam bit DEB_ON = 1'b1;
`else
   localparam bit DEB_ON = 1'b0;
`endif

   // Detection stays off until the synchroniser, the optional filter and the
   // prev register all hold real input levels.
   localparam int PRIME_LEN = SYNC_STAGES + 1 + (DEB_ON ? DEB_CYCLES : 0);
   localparam int PRIME_W   = $clog2(PRIME_LEN + 1);
   localparam int POP_W     = $clog2(WIDTH + 1);
   // One bit wider than either addend so the saturation test cannot overflow.
   localparam int SUM_W     = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t               state_reg;
   logic [PRIME_W-1:0]   prime_cnt_reg;

   logic [WIDTH-1:0]     s_sync;        // synchronised levels
   logic [WIDTH-1:0]     det_lvl;       // level the detector looks at
   logic [WIDTH-1:0]     prev_reg;      // detector level one cycle earlier
   logic [WIDTH-1:0]     pulse_reg;
   logic [WIDTH-1:0]     pulse_next;
   logic [WIDTH-1:0]     sticky_reg;
   logic                 irq_reg;
   logic [CNT_W-1:0]     edge_cnt_reg;
   logic [CNT_W-1:0]     edge_cnt_next;
   logic [POP_W-1:0]     pop_cnt;
   logic [CNT_W-1:0]     cnt_base;
   logic [SUM_W-1:0]     cnt_sum;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chan
         logic [SYNC_STAGES-1:0] sync_reg;

         // Shift the raw input through the synchroniser chain.
         always_ff @(posedge clock) begin
            if (rst) begin
               sync_reg <= '0;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], din[gi]};
            end
         end

         assign s_sync[gi] = sync_reg[SYNC_STAGES-1];

`ifdef EDGE_DETECT_MULTI_DEBOUNCE_EN
         localparam int DEB_W = $clog2(DEB_CYCLES + 1);
         logic [DEB_W-1:0] deb_cnt_reg;
         logic             f_reg;

         // Flip the filtered level only after DEB_CYCLES consecutive
         // disagreeing samples; any agreeing sample restarts the run.
         always_ff @(posedge clock) begin
            if (rst) begin
               deb_cnt_reg <= '0;
               f_reg       <= 1'b0;
            end else if (s_sync[gi] == f_reg) begin
               deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
               deb_cnt_reg <= '0;
               f_reg       <= ~f_reg;
            end else begin
               deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
         end

         assign det_lvl[gi] = f_reg;
`else
         assign det_lvl[gi] = s_sync[gi];
`endif
      end
   endgenerate

   // Priming sequencer: hold off detection for PRIME_LEN cycles after reset.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_reg     <= ST_PRIME;
         prime_cnt_reg <= '0;
      end else begin
         case (state_reg)
            ST_PRIME: begin
               if (prime_cnt_reg == PRIME_W'(PRIME_LEN - 1)) begin
                  state_reg <= ST_RUN;
               end else begin
                  prime_cnt_reg <= prime_cnt_reg + PRIME_W'(1);
               end
            end
            ST_RUN: begin
               state_reg <= ST_RUN;
            end
            default: begin
               state_reg     <= ST_PRIME;
               prime_cnt_reg <= '0;
            end
         endcase
      end
   end

   // Edge decode with the live mode selects; a mode change alone never
   // produces a pulse because it does not touch det_lvl or prev_reg.
   always_comb begin
      pulse_next = '0;
      if (state_reg == ST_RUN) begin
         pulse_next = (det_lvl & ~prev_reg & mode_rise) |
                      (~det_lvl & prev_reg & mode_fall);
      end
   end

   // Register the previous level and the one-cycle pulses.
   always_ff @(posedge clock) begin
      if (rst) begin
         prev_reg  <= '0;
         pulse_reg <= '0;
      end else begin
         prev_reg  <= det_lvl;
         pulse_reg <= pulse_next;
      end
   end

   // Count this cycle's pulses onto the total, restarting from zero on
   // cnt_clr and clamping at the all-ones value.
   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_cnt = pop_cnt + POP_W'(pulse_reg[i]);
      end
      cnt_base      = cnt_clr ? '0 : edge_cnt_reg;
      cnt_sum       = SUM_W'(cnt_base) + SUM_W'(pop_cnt);
      edge_cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
   end

   // Sticky flags (a new pulse beats a simultaneous clear), interrupt and counter.
   always_ff @(posedge clock) begin
      if (rst) begin
         sticky_reg   <= '0;
         irq_reg      <= 1'b0;
         edge_cnt_reg <= '0;
      end else begin
         sticky_reg   <= (sticky_reg & ~clr) | pulse_reg;
         irq_reg      <= |(sticky_reg & irq_en);
         edge_cnt_reg <= edge_cnt_next;
      end
   end

   assign pulse    = pulse_reg;
   assign sticky   = sticky_reg;
   assign irq      = irq_reg;
   assign edge_cnt = edge_cnt_reg;

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model built from input history (a queue of sampled din values).
// Build with EDGE_DETECT_MULTI_DEBOUNCE_EN defined to exercise the filter.

module tb_edge_detect_multi;

   localparam int W   = 4;
   localparam int S   = 2;
   localparam int CW  = 8;
   localparam int DEB = 4;
`ifdef EDGE_DETECT_MULTI_DEBOUNCE_EN
   localparam int DE = DEB;
`else
   localparam int DE = 0;
`endif
   localparam int L     = S + DE;                  // din set before edge N -> pulse after edge N+L
   localparam int PRIME = S + DE + 1;              // suppressed edges after reset release
   localparam int H     = (DE == 0) ? 1 : DE + 1;  // shortest level hold that reaches the detector

   logic          clock = 1'b0;
   logic          rst;
   logic [W-1:0]  din, mode_rise, mode_fall, irq_en, clr;
   logic          cnt_clr;
   logic [W-1:0]  pulse, sticky;
   logic          irq;
   logic [CW-1:0] edge_cnt;

   int n_chk = 0;
   int n_err = 0;
   int cyc_no = 0;
   bit chk_on = 1'b0;

   edge_detect_multi #(
      .WIDTH(W), .SYNC_STAGES(S), .CNT_W(CW), .DEB_CYCLES(DEB)
   ) dut (
      .clock(clock), .rst(rst), .din(din), .mode_rise(mode_rise),
      .mode_fall(mode_fall), .irq_en(irq_en), .clr(clr), .cnt_clr(cnt_clr),
      .pulse(pulse), .sticky(sticky), .irq(irq), .edge_cnt(edge_cnt)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   int           m_k;          // rising edges since reset release
   logic [W-1:0] m_hist[$];    // din as sampled at each of those edges
   logic [W-1:0] m_lvl_prev, m_f, m_fprev;
   int           m_run[W];
   logic [W-1:0] m_pulse, m_sticky;
   logic         m_irq;
   int           m_cnt;

   task automatic model_update();
      logic [W-1:0] lvl, det, detp;
      int pop, c;
      if (rst) begin
         m_k = 0; m_hist.delete();
         m_lvl_prev = '0; m_f = '0; m_fprev = '0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
         m_pulse = '0; m_sticky = '0; m_irq = 1'b0; m_cnt = 0;
      end else begin
         m_k++;
         m_hist.push_back(din);
         // Level reaching the detector: din from S edges ago, zero before that.
         lvl = (m_k > S) ? m_hist[m_k-S-1] : '0;
         if (DE == 0) begin
            det = lvl; detp = m_lvl_prev; m_lvl_prev = lvl;
         end else begin
            det = m_f; detp = m_fprev; m_fprev = m_f;
            for (int i = 0; i < W; i++) begin
               if (lvl[i] != m_f[i]) begin
                  m_run[i]++;
                  if (m_run[i] == DE) begin m_f[i] = ~m_f[i]; m_run[i] = 0; end
               end else begin
                  m_run[i] = 0;
               end
            end
         end
         pop = $countones(m_pulse);
         c = cnt_clr ? pop : m_cnt + pop;
         if (c > (2**CW) - 1) c = (2**CW) - 1;
         m_irq    = |(m_sticky & irq_en);
         m_sticky = (m_sticky & ~clr) | m_pulse;
         m_pulse  = (m_k <= PRIME) ? '0 :
                    ((det & ~detp & mode_rise) | (~det & detp & mode_fall));
         m_cnt    = c;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_no, act, exp);
      end
   endtask

   // One clock: model advances on the edge, outputs are inspected on the falling edge.
   task automatic cyc();
      @(posedge clock);
      model_update();
      cyc_no++;
      @(negedge clock);
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clock) begin
      if (chk_on) begin
         chk("pulse",    32'(pulse),    32'(m_pulse));
         chk("sticky",   32'(sticky),   32'(m_sticky));
         chk("irq",      32'(irq),      32'(m_irq));
         chk("edge_cnt", 32'(edge_cnt), 32'(m_cnt));
      end
   end

   initial begin
      int first, second, np1, np2, hb;
      rst = 1'b1; din = '1; mode_rise = '1; mode_fall = '1; irq_en = '1;
      clr = '0; cnt_clr = 1'b0;

      // 1: level high through reset release -> nothing happens
      repeat (3) cyc();
      chk_on = 1'b1;
      chk("rst_pulse", 32'(pulse), 0);
      chk("rst_sticky", 32'(sticky), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_cnt", 32'(edge_cnt), 0);
      rst = 1'b0;
      for (int j = 0; j < 20; j++) begin
         cyc();
         chk("hi_at_release", 32'({pulse, sticky, edge_cnt}), 0);
      end
      $display("txn 1 high-at-release done, cycle %0d", cyc_no);

      // 2: single rising edge latency
      rst = 1'b1; din = '0; cyc(); cyc(); rst = 1'b0;
      mode_rise = 4'b0001; mode_fall = '0; irq_en = 4'b0001;
      repeat (PRIME + 2) cyc();
      din[0] = 1'b1;
      for (int j = 0; j <= L + 2; j++) begin
         cyc();
         chk("lat_pulse", 32'(pulse), (j == L) ? 1 : 0);
         if (j == L + 1) begin
            chk("lat_sticky", 32'(sticky), 1);
            chk("lat_cnt", 32'(edge_cnt), 1);
            chk("lat_irq_early", 32'(irq), 0);
         end
         if (j == L + 2) chk("lat_irq", 32'(irq), 1);
      end
      $display("txn 2 rise latency done, cycle %0d", cyc_no);

      // 3: ch1 any-edge, ch2 disabled, same pulse stimulus
      mode_rise = 4'b0010; mode_fall = 4'b0010;
      hb = (DE == 0) ? 3 : DE + 2;
      first = -1; second = -1; np1 = 0; np2 = 0;
      din[1] = 1'b1; din[2] = 1'b1;
      for (int j = 0; j <= 2 * hb + L + 4; j++) begin
         if (j == hb) begin din[1] = 1'b0; din[2] = 1'b0; end
         cyc();
         if (pulse[1]) begin
            np1++;
            if (first < 0) first = j; else second = j;
         end
         if (pulse[2]) np2++;
      end
      chk("any_pulses", np1, 2);
      chk("any_gap", second - first, hb);
      chk("off_ch2", np2, 0);
      chk("any_cnt", 32'(edge_cnt), 3);
      $display("txn 3 mode select done, cycle %0d", cyc_no);

      // 4: saturation and counter clear
      mode_rise = '1; mode_fall = '0; din = '0;
      repeat (L + 3) cyc();
      cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
      for (int r = 0; r < 63; r++) begin
         din = '1; repeat (H) cyc();
         din = '0; repeat (H) cyc();
      end
      din = 4'b0001; repeat (H) cyc();
      din = '0; repeat (L + 3) cyc();
      chk("cnt_253", 32'(edge_cnt), 253);
      din = '1;
      for (int j = 0; j <= L + 1; j++) begin
         cyc();
         if (j == L) chk("sat_pulse", 32'(pulse), 4'hF);
         if (j == L + 1) chk("sat_cnt", 32'(edge_cnt), 255);
      end
      mode_fall = 4'b0001; din[0] = 1'b0;
      for (int j = 0; j <= L + 1; j++) begin
         cyc();
         if (j == L) cnt_clr = 1'b1;
         if (j == L + 1) begin chk("clr_cnt", 32'(edge_cnt), 1); cnt_clr = 1'b0; end
      end
      $display("txn 4 saturation done, cycle %0d", cyc_no);

      // 5: sticky set-wins, clear, irq drop, reset mid-edge
      clr = '1; cyc(); clr = '0;
      mode_rise = 4'b0001; mode_fall = 4'b0001; irq_en = 4'b0001;
      din[0] = 1'b1; repeat (L + 2) cyc();
      chk("st_set", 32'(sticky), 1);
      din[0] = 1'b0;
      for (int j = 0; j <= L + 3; j++) begin
         cyc();
         if (j == L) clr = 4'b0001;
         if (j == L + 1) chk("st_setwins", 32'(sticky), 1);
         if (j == L + 2) begin
            chk("st_cleared", 32'(sticky), 0);
            chk("irq_hold", 32'(irq), 1);
            clr = '0;
         end
         if (j == L + 3) chk("irq_drop", 32'(irq), 0);
      end
      din[0] = 1'b1; cyc();
      rst = 1'b1; cyc();
      chk("rstmid_out", 32'({pulse, sticky, irq, edge_cnt}), 0);
      rst = 1'b0;
      for (int j = 0; j < PRIME + 3; j++) begin
         cyc();
         chk("rstmid_quiet", 32'(pulse), 0);
      end
      $display("txn 5 sticky/reset done, cycle %0d", cyc_no);

      // 6: glitch rejection and debounced latency on ch3
      mode_rise = 4'b1000; mode_fall = '0;
      din[3] = 1'b0; repeat (L + 4) cyc();
      din[3] = 1'b1; cyc(); cyc(); din[3] = 1'b0;
      np2 = 0;
      for (int j = 0; j < 15; j++) begin cyc(); if (pulse[3]) np2++; end
`ifdef EDGE_DETECT_MULTI_DEBOUNCE_EN
      chk("deb_glitch", np2, 0);
`endif
      din[3] = 1'b1;
      for (int j = 0; j <= L + DEB + 4; j++) begin
         if (j == 6) din[3] = 1'b0;
         cyc();
`ifdef EDGE_DETECT_MULTI_DEBOUNCE_EN
         chk("deb_lat", 32'(pulse[3]), (j == L) ? 1 : 0);
`endif
      end
      $display("txn 6 debounce done, cycle %0d", cyc_no);

      // Randomized traffic, model-checked every cycle
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, (n < 400) ? 2 : 9) == 0) din[i] = ~din[i];
         if ($urandom_range(0, 15) == 0) begin
            mode_rise = W'($urandom); mode_fall = W'($urandom); irq_en = W'($urandom);
         end
         clr     = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
         cnt_clr = ($urandom_range(0, 31) == 0);
         rst     = ($urandom_range(0, 249) == 0);
         cyc();
         if (n % 100 == 99)
            $display("txn random block %0d done, cycle %0d", n / 100, cyc_no);
      end
      rst = 1'b0; clr = '0; cnt_clr = 1'b0;
      cyc();
      chk_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
